bitmap_rom_reader: RTL and testbench

// - Read-side master for the 1-bit bitmap ROMs on the LCD path: walks a stored IMG_W x IMG_H monochrome image
//   in raster order, drives the ROM address and consumes its 1-cycle-latency data.
// - Expands each bit to an RGB565 foreground/background colour; emits a valid/ready pixel stream to the LCD writer.

---
 rtl/bitmap_rom_reader_pkg.sv | 21 ++
 rtl/bitmap_rom_reader_if.sv | 39 +++
 rtl/bitmap_rom_reader_pix_skid_fifo.sv | 43 ++++
 rtl/bitmap_rom_reader.sv | 139 +++++++++++++
 tb/tb_bitmap_rom_reader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_rom_reader_pkg.sv
// Shared LCD-path definitions: pixel width, reader FSM encoding, width helper.
package bitmap_rom_reader_pkg;

  localparam int RGB565_W = 16;

  typedef logic [1:0] fsm_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ceil(log2(value)), never below 1 so a 1-pixel dimension still gets a real bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bitmap_rom_reader_if.sv
// Control, ROM read bus and pixel stream of the bitmap ROM reader.
// master = the reader itself, slave = the surrounding LCD path.
interface bitmap_rom_reader_if
  import bitmap_rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int COLOR_WIDTH = RGB565_W
);
  localparam int XW = clog2_min1(IMG_W);
  localparam int YW = clog2_min1(IMG_H);

  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [COLOR_WIDTH-1:0] fg_color;
  logic [COLOR_WIDTH-1:0] bg_color;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic                   rom_data;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [COLOR_WIDTH-1:0] pix_data;
  logic [XW-1:0]          pix_x;
  logic [YW-1:0]          pix_y;
  logic                   pix_last;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, base_addr, fg_color, bg_color, rom_data, pix_ready,
    output rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done
  );

  modport slave (
    output start, base_addr, fg_color, bg_color, rom_data, pix_ready,
    input  rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done
  );

endinterface

// File: rtl/bitmap_rom_reader_pix_skid_fifo.sv
// Two-entry FIFO holding {bit, x, y, last} between the ROM and the pixel port.
// Pure storage: the parent guarantees no push when full and no pop when empty.
module pix_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bitmap_rom_reader.sv
// Raster-order reader for a 1-bit bitmap ROM with 1-cycle read latency.
// Each bit becomes a fg/bg colour on a valid/ready pixel stream.
module bitmap_rom_reader
  import bitmap_rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int COLOR_WIDTH = RGB565_W
) (
  input  logic                clk,
  input  logic                rst,
  bitmap_rom_reader_if.master bus
);

  localparam int XW = clog2_min1(IMG_W);
  localparam int YW = clog2_min1(IMG_H);
  localparam int TW = XW + YW + 2;   // {bit, x, y, last}

  fsm_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [XW-1:0]          ix_q, ix_d;
  logic [YW-1:0]          iy_q, iy_d;
  logic                   inflight_q;
  logic [XW-1:0]          tx_q;
  logic [YW-1:0]          ty_q;
  logic                   tlast_q;
  logic [COLOR_WIDTH-1:0] fg_q, bg_q;

  logic [1:0]    count;
  logic [TW-1:0] head;
  logic          head_bit, head_last;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          accept, pix_valid, pop, issue, at_last, last_issue;
  logic [2:0]    occ_net;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign pix_valid = (count != 2'd0);
  assign pop       = pix_valid && bus.pix_ready;

  // Credit: buffered + in-flight words, net of the word leaving this cycle,
  // must leave room for one more. Counting the same-cycle pop is what lets a
  // 2-entry buffer sustain one pixel per clock with ready held high.
  assign occ_net    = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == ST_RUN) && (occ_net < 3'd2);
  assign at_last    = (ix_q == XW'(IMG_W - 1)) && (iy_q == YW'(IMG_H - 1));
  assign last_issue = issue && at_last;

  assign head_bit  = head[TW-1];
  assign head_x    = head[TW-2 -: XW];
  assign head_y    = head[YW:1];
  assign head_last = head[0];

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && head_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address and raster issue counters
  always_comb begin
    addr_d = addr_q;
    ix_d   = ix_q;
    iy_d   = iy_q;
    if (accept) begin
      addr_d = bus.base_addr;
      ix_d   = '0;
      iy_d   = '0;
    end else if (issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (ix_q == XW'(IMG_W - 1)) begin
        ix_d = '0;
        iy_d = (iy_q == YW'(IMG_H - 1)) ? '0 : iy_q + YW'(1);
      end else begin
        ix_d = ix_q + XW'(1);
      end
    end
  end

  // Control registers; reset aborts a frame and drops any in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      ix_q       <= '0;
      iy_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      inflight_q <= issue;
    end
  end

  // Tag of the read in flight, and colours captured for the whole frame
  always_ff @(posedge clk) begin
    if (issue) begin
      tx_q    <= ix_q;
      ty_q    <= iy_q;
      tlast_q <= at_last;
    end
    if (accept) begin
      fg_q <= bus.fg_color;
      bg_q <= bus.bg_color;
    end
  end

  pix_skid_fifo #(
    .WIDTH (TW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   ({bus.rom_data, tx_q, ty_q, tlast_q}),
    .dout_o  (head),
    .count_o (count)
  );

  // Head fields are forced to zero while empty so idle/reset outputs read 0
  assign bus.rom_addr  = addr_q;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_data  = pix_valid ? (head_bit ? fg_q : bg_q) : '0;
  assign bus.pix_x     = pix_valid ? head_x : '0;
  assign bus.pix_y     = pix_valid ? head_y : '0;
  assign bus.pix_last  = pix_valid && head_last;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_bitmap_rom_reader.sv
// Directed bench for bitmap_rom_reader: 4x3, 2x2 (address wrap) and 1x1 instances.
module tb_bitmap_rom_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_s;
  logic        start_s;
  logic [16:0] base_s;
  logic [15:0] fg_s, bg_s;
  logic        ready_s;
  int          rom_md;   // 0: bit = addr[0], 1: all ones, 2: all zeros
  int          sel;      // which instance the bench is talking to

  bitmap_rom_reader_if #(.ADDR_WIDTH(17), .IMG_W(4), .IMG_H(3), .COLOR_WIDTH(16)) b43 ();
  bitmap_rom_reader_if #(.ADDR_WIDTH(17), .IMG_W(2), .IMG_H(2), .COLOR_WIDTH(16)) b22 ();
  bitmap_rom_reader_if #(.ADDR_WIDTH(17), .IMG_W(1), .IMG_H(1), .COLOR_WIDTH(16)) b11 ();

  bitmap_rom_reader #(.ADDR_WIDTH(17), .IMG_W(4), .IMG_H(3), .COLOR_WIDTH(16))
    dut43 (.clk(clk), .rst(rst_s), .bus(b43));
  bitmap_rom_reader #(.ADDR_WIDTH(17), .IMG_W(2), .IMG_H(2), .COLOR_WIDTH(16))
    dut22 (.clk(clk), .rst(rst_s), .bus(b22));
  bitmap_rom_reader #(.ADDR_WIDTH(17), .IMG_W(1), .IMG_H(1), .COLOR_WIDTH(16))
    dut11 (.clk(clk), .rst(rst_s), .bus(b11));

  assign b43.start = start_s && (sel == 0);
  assign b22.start = start_s && (sel == 1);
  assign b11.start = start_s && (sel == 2);
  assign b43.base_addr = base_s;
  assign b22.base_addr = base_s;
  assign b11.base_addr = base_s;
  assign b43.fg_color = fg_s;
  assign b22.fg_color = fg_s;
  assign b11.fg_color = fg_s;
  assign b43.bg_color = bg_s;
  assign b22.bg_color = bg_s;
  assign b11.bg_color = bg_s;
  assign b43.pix_ready = ready_s;
  assign b22.pix_ready = ready_s;
  assign b11.pix_ready = ready_s;

  function automatic logic rom_bit(input logic [16:0] a);
    if (rom_md == 1) return 1'b1;
    if (rom_md == 2) return 1'b0;
    return a[0];
  endfunction

  // Synchronous ROM models: data 1 clk after address
  always @(posedge clk) b43.rom_data <= rom_bit(b43.rom_addr);
  always @(posedge clk) b22.rom_data <= rom_bit(b22.rom_addr);
  always @(posedge clk) b11.rom_data <= rom_bit(b11.rom_addr);

  logic [16:0] o_addr;
  logic [15:0] o_data;
  logic [1:0]  o_x, o_y;
  logic        o_valid, o_last, o_busy, o_done;

  always_comb begin
    o_addr = '0; o_data = '0; o_x = '0; o_y = '0;
    o_valid = 1'b0; o_last = 1'b0; o_busy = 1'b0; o_done = 1'b0;
    case (sel)
      0: begin
        o_addr = b43.rom_addr; o_data = b43.pix_data; o_x = b43.pix_x; o_y = b43.pix_y;
        o_valid = b43.pix_valid; o_last = b43.pix_last; o_busy = b43.busy; o_done = b43.done;
      end
      1: begin
        o_addr = b22.rom_addr; o_data = b22.pix_data; o_x = 2'(b22.pix_x); o_y = 2'(b22.pix_y);
        o_valid = b22.pix_valid; o_last = b22.pix_last; o_busy = b22.busy; o_done = b22.done;
      end
      default: begin
        o_addr = b11.rom_addr; o_data = b11.pix_data; o_x = 2'(b11.pix_x); o_y = 2'(b11.pix_y);
        o_valid = b11.pix_valid; o_last = b11.pix_last; o_busy = b11.busy; o_done = b11.done;
      end
    endcase
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rom_addr"}, o_addr, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
  endtask

  // One frame on the selected instance; abort_at >= 0 resets after that many pixels
  task automatic run_frame(input int w, input int h, input logic [16:0] base, input int md,
                           input bit rnd, input bit mid_start, input bit fg_chg, input int abort_at);
    int n, k, c, first_c, last_c, issued;
    bit cred_bad, step_bad, exp_bit;
    logic [16:0] prev_addr, diff, exp_addr;
    logic [15:0] fg0;
    n = w * h; k = 0; c = 0; first_c = -1; last_c = -1;
    cred_bad = 1'b0; step_bad = 1'b0;
    rom_md = md; fg0 = fg_s;
    @(negedge clk); base_s = base; start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("valid_first_cycle", o_valid, 0);
    check("addr_is_base", o_addr, base);
    prev_addr = o_addr;
    while (c < 400 && k < n) begin
      if (c > 0) @(negedge clk);
      if (o_addr != prev_addr) begin
        if (o_addr != 17'(prev_addr + 17'd1)) step_bad = 1'b1;
        prev_addr = o_addr;
      end
      diff = o_addr - base;
      issued = int'(diff);
      if (issued - k > 2) cred_bad = 1'b1;
      if (abort_at >= 0 && k == abort_at) begin
        rst_s = 1'b1; ready_s = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");
        rst_s = 1'b0; ready_s = 1'b1;
        @(negedge clk);
        check("no_done_after_abort", o_done, 0);
        check("idle_after_abort", o_busy, 0);
        return;
      end
      ready_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_s = mid_start && (c == 0);
      if (mid_start && c == 0) base_s = 17'h000AA;
      if (fg_chg && c == 3) fg_s = 16'h07E0;
      if (o_valid) begin
        if (first_c < 0) first_c = c;
        if (ready_s) begin
          exp_addr = 17'(base + 17'(k));
          exp_bit = (md == 1) ? 1'b1 : (md == 2) ? 1'b0 : exp_addr[0];
          check("pix_x", o_x, k % w);
          check("pix_y", o_y, k / w);
          check("pix_last", o_last, (k == n - 1) ? 1 : 0);
          check("pix_data", o_data, exp_bit ? fg0 : bg_s);
          k++;
          last_c = c;
        end
      end
      c++;
    end
    start_s = 1'b0; ready_s = 1'b1;
    check("frame_pixel_count", k, n);
    check("first_valid_latency", first_c, 2);
    if (!rnd) check("throughput_last_cycle", last_c, n + 1);
    check("credit_bound", cred_bad, 0);
    check("addr_step", step_bad, 0);
    @(negedge clk);
    check("done_pulse", o_done, 1);
    check("done_no_valid", o_valid, 0);
    check("busy_with_done", o_busy, 1);
    check("addr_end", o_addr, 17'(base + 17'(n)));
    start_s = 1'b1;   // lands on the DONE->IDLE edge and must not be taken
    @(negedge clk);
    start_s = 1'b0;
    check("done_cleared", o_done, 0);
    check("start_at_done_ignored", o_busy, 0);
    fg_s = fg0;
  endtask

  initial begin
    rst_s = 1'b1; start_s = 1'b0; base_s = '0; ready_s = 1'b1;
    fg_s = 16'hF800; bg_s = 16'h001F; rom_md = 0; sel = 0;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle_outputs("reset");
    end
    sel = 0;
    rst_s = 1'b0;

    // 4x3 raster, ready held high
    run_frame(4, 3, 17'h00100, 0, 1'b0, 1'b0, 1'b0, -1);
    // same frame with random backpressure
    run_frame(4, 3, 17'h00100, 0, 1'b1, 1'b0, 1'b0, -1);
    // all-ones then all-zeros ROM, fg changed mid-frame must not matter
    run_frame(4, 3, 17'h00100, 1, 1'b0, 1'b0, 1'b1, -1);
    run_frame(4, 3, 17'h00100, 2, 1'b1, 1'b0, 1'b1, -1);
    // reset at pixel 5, then a fresh complete frame
    run_frame(4, 3, 17'h00100, 0, 1'b0, 1'b0, 1'b0, 5);
    run_frame(4, 3, 17'h00100, 0, 1'b0, 1'b0, 1'b0, -1);
    // extra start while running
    run_frame(4, 3, 17'h00100, 0, 1'b1, 1'b1, 1'b0, -1);

    // 2x2 across the address wrap
    sel = 1;
    run_frame(2, 2, 17'h1FFFE, 0, 1'b0, 1'b0, 1'b0, -1);

    // 1x1 with a start pulsed during RUN
    sel = 2;
    run_frame(1, 1, 17'h00021, 0, 1'b0, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
